// File: rtl/lcd_cmd_issuer.sv
// Host-side command source for LCD_CTRL: buffers a command script in a FIFO,
// issues it one command at a time while honouring busy, then waits for done.
module lcd_cmd_issuer #(
    parameter int CMD_W   = 4,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [CMD_W-1:0]           wr_cmd,
    input  logic                       start,
    input  logic                       busy,
    input  logic                       done,
    output logic [CMD_W-1:0]           cmd,
    output logic                       cmd_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     issued_cnt,
    output logic                       running,
    output logic                       finish,
    output logic                       error,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_GAP       = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FINISH    = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t              state_r;
    logic [CMD_W-1:0]    mem_r [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic [TO_W-1:0]     to_cnt_r;
    logic [CMD_W-1:0]    cmd_r;
    logic                cmd_valid_r;
    logic [CW-1:0]       issued_cnt_r;
    logic                running_r;
    logic                finish_r;
    logic                error_r;
    logic                overflow_r;
    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic [CMD_W-1:0]    head_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = wr_en && !full_s;
    assign pop_s   = (state_r == S_RUN) && !empty_s && !busy;
    assign head_s  = mem_r[rd_ptr_r];

    assign cmd        = cmd_r;
    assign cmd_valid  = cmd_valid_r;
    assign full       = full_s;
    assign empty      = empty_s;
    assign issued_cnt = issued_cnt_r;
    assign running    = running_r;
    assign finish     = finish_r;
    assign error      = error_r;
    assign overflow   = overflow_r;

    // FIFO storage; contents are invalidated through the pointers, not cleared.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_cmd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; only a reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (wr_en && full_s) begin
            overflow_r <= 1'b1;
        end
    end

    // Issue sequencer with its registered outputs and busy/done watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            cmd_r        <= {CMD_W{1'b0}};
            cmd_valid_r  <= 1'b0;
            issued_cnt_r <= {CW{1'b0}};
            running_r    <= 1'b0;
            finish_r     <= 1'b0;
            error_r      <= 1'b0;
            to_cnt_r     <= {TO_W{1'b0}};
        end else begin
            cmd_valid_r <= 1'b0;
            case (state_r)
                S_IDLE, S_FINISH, S_ERROR: begin
                    if (start) begin
                        state_r      <= S_RUN;
                        running_r    <= 1'b1;
                        issued_cnt_r <= {CW{1'b0}};
                        finish_r     <= 1'b0;
                        error_r      <= 1'b0;
                        to_cnt_r     <= {TO_W{1'b0}};
                    end
                end
                S_RUN: begin
                    if (empty_s) begin
                        state_r <= S_WAIT_DONE;
                        if (!busy) begin
                            to_cnt_r <= {TO_W{1'b0}};
                        end
                    end else if (!busy) begin
                        cmd_r       <= head_s;
                        cmd_valid_r <= 1'b1;
                        to_cnt_r    <= {TO_W{1'b0}};
                        state_r     <= S_GAP;
                        if (issued_cnt_r != CW'(DEPTH)) begin
                            issued_cnt_r <= issued_cnt_r + CW'(1);
                        end
                    end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                        error_r   <= 1'b1;
                        running_r <= 1'b0;
                        state_r   <= S_ERROR;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                // One-cycle bubble lets LCD_CTRL raise busy before it is sampled again.
                S_GAP: begin
                    state_r <= S_RUN;
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        finish_r  <= 1'b1;
                        running_r <= 1'b0;
                        state_r   <= S_FINISH;
                    end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                        error_r   <= 1'b1;
                        running_r <= 1'b0;
                        state_r   <= S_ERROR;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Directed-sequence bench for lcd_cmd_issuer with random command data, a queue
// model of the script and a small LCD_CTRL busy responder.
module tb_lcd_cmd_issuer;

    localparam int DEPTH = 64;
    localparam int TMO   = 16;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_cmd;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       full;
    logic       empty;
    logic [6:0] issued_cnt;
    logic       running;
    logic       finish;
    logic       error;
    logic       overflow;

    lcd_cmd_issuer #(
        .CMD_W   (4),
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO),
        .TO_W    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_cmd     (wr_cmd),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .full       (full),
        .empty      (empty),
        .issued_cnt (issued_cnt),
        .running    (running),
        .finish     (finish),
        .error      (error),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         errors;
    int         cyc;
    int         last_cv_cyc;
    int         run_pulses;
    int         busy_mode;
    int         busy_left;
    logic       prev_cv;
    logic       exp_ovf;
    logic [3:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the push, sample outputs 1ns after the edge, respond with busy.
    task automatic tick();
        logic       busy_at_edge;
        logic [3:0] exp_cmd;
        if (wr_en && rst) begin
            if (q.size() < DEPTH) q.push_back(wr_cmd);
            else exp_ovf = 1'b1;
        end
        busy_at_edge = busy;
        @(posedge clk);
        #1;
        cyc++;
        if (cmd_valid === 1'b1) begin
            chk("cv_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                exp_cmd = q.pop_front();
                chk("cmd_order", {28'd0, cmd}, {28'd0, exp_cmd});
            end
            chk("cv_busy_low", {31'd0, busy_at_edge}, 32'd0);
            chk("cv_not_b2b", {31'd0, prev_cv}, 32'd0);
            if (run_pulses > 0 && busy_mode == 0)
                chk("gap_spacing", cyc - last_cv_cyc, 32'd2);
            last_cv_cyc = cyc;
            run_pulses++;
        end
        prev_cv = cmd_valid;
        case (busy_mode)
            1: begin
                if (cmd_valid === 1'b1) busy_left = 3;
                busy = (busy_left != 0);
                if (busy_left > 0) busy_left--;
            end
            2: begin
                if (cmd_valid === 1'b1) busy = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    endtask

    task automatic push(input logic [3:0] c);
        wr_en  = 1'b1;
        wr_cmd = c;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic start_run();
        run_pulses = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_running", {31'd0, running}, 32'd1);
        chk("start_clr_err", {31'd0, error}, 32'd0);
    endtask

    task automatic drain();
        for (int g = 0; g < 2000 && q.size() != 0; g++) tick();
        chk("drain_q", q.size(), 32'd0);
    endtask

    task automatic finish_run();
        repeat (3) tick();
        chk("no_early_finish", {31'd0, finish}, 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("finish_set", {31'd0, finish}, 32'd1);
        chk("finish_idle", {31'd0, running}, 32'd0);
        chk("finish_no_err", {31'd0, error}, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; last_cv_cyc = 0; run_pulses = 0;
        busy_mode = 0; busy_left = 0; prev_cv = 1'b0; exp_ovf = 1'b0;
        rst = 1'b0; wr_en = 1'b0; wr_cmd = 4'd0; start = 1'b0; busy = 1'b0; done = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_cv", {31'd0, cmd_valid}, 32'd0);
        chk("rst_cmd", {28'd0, cmd}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_issued", {25'd0, issued_cnt}, 32'd0);
        chk("rst_flags", {28'd0, running, finish, error, overflow}, 32'd0);
        rst = 1'b1;
        tick();

        // 60-command script with a 3-cycle busy responder; done mid-run is ignored
        for (int i = 0; i < 60; i++) push(4'($urandom_range(0, 15)));
        busy_mode = 1;
        start_run();
        for (int g = 0; g < 2000 && q.size() != 0; g++) begin
            done = (run_pulses == 30);
            tick();
        end
        done = 1'b0;
        chk("s1_drain", q.size(), 32'd0);
        chk("s1_pulses", run_pulses, 32'd60);
        chk("s1_issued", {25'd0, issued_cnt}, 32'd60);
        chk("s1_done_ignored", {31'd0, finish}, 32'd0);
        finish_run();

        // Busy permanently low: pulses every other cycle
        busy_mode = 0;
        for (int i = 0; i < 5; i++) push(4'($urandom_range(0, 15)));
        start_run();
        drain();
        chk("s2_pulses", run_pulses, 32'd5);
        tick(); tick();
        chk("s2_wait_running", {31'd0, running}, 32'd1);
        finish_run();

        // 65 pushes without start: the last one overflows and is dropped
        for (int i = 0; i < 64; i++) push(4'($urandom_range(0, 15)));
        chk("s3_full", {31'd0, full}, 32'd1);
        chk("s3_no_ovf_yet", {31'd0, overflow}, 32'd0);
        push(4'($urandom_range(0, 15)));
        chk("s3_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("s3_still_full", {31'd0, full}, 32'd1);
        busy_mode = 1;
        start_run();
        drain();
        chk("s3_issued_sat", {25'd0, issued_cnt}, 32'd64);
        chk("s3_empty", {31'd0, empty}, 32'd1);
        finish_run();

        // Busy stuck high after the first command: watchdog trips
        for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 15)));
        busy_mode = 2;
        start_run();
        for (int g = 0; g < 50 && run_pulses == 0; g++) tick();
        chk("s4_first_cmd", run_pulses, 32'd1);
        repeat (16) tick();
        chk("s4_err_not_yet", {31'd0, error}, 32'd0);
        tick();
        chk("s4_err", {31'd0, error}, 32'd1);
        chk("s4_stopped", {31'd0, running}, 32'd0);
        chk("s4_retained", {31'd0, empty}, 32'd0);
        busy_mode = 0;
        busy = 1'b0;
        start_run();
        drain();
        chk("s4_resume_issued", {25'd0, issued_cnt}, 32'd3);
        finish_run();

        // Push coinciding with the pop of the only entry
        push(4'($urandom_range(0, 15)));
        start_run();
        wr_en  = 1'b1;
        wr_cmd = 4'($urandom_range(0, 15));
        tick();
        wr_en  = 1'b0;
        chk("s5_pop_seen", run_pulses, 32'd1);
        chk("s5_count_one", {31'd0, empty}, 32'd0);
        drain();
        chk("s5_issued", {25'd0, issued_cnt}, 32'd2);
        finish_run();

        // Asynchronous reset while cmd_valid is high
        for (int i = 0; i < 10; i++) push(4'($urandom_range(0, 15)));
        busy_mode = 1;
        start_run();
        for (int g = 0; g < 50 && run_pulses == 0; g++) tick();
        chk("s6_cv_high", {31'd0, cmd_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("s6_cv_async", {31'd0, cmd_valid}, 32'd0);
        q.delete();
        exp_ovf = 1'b0; busy_mode = 0; busy_left = 0; busy = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("s6_empty", {31'd0, empty}, 32'd1);
        chk("s6_issued", {25'd0, issued_cnt}, 32'd0);
        chk("s6_flags", {28'd0, running, finish, error, overflow}, 32'd0);
        push(4'($urandom_range(0, 15)));
        push(4'($urandom_range(0, 15)));
        start_run();
        drain();
        chk("s6_issued_after", {25'd0, issued_cnt}, 32'd2);
        finish_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
